// File: rtl/operand_fetch_pkg.sv
// Shared sizing constants for the operand fetch stage and its busy scoreboard.
package operand_fetch_pkg;
  localparam int WIDTH    = 32;
  localparam int NREGS    = 32;
  localparam int AW       = 5;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard of registers with a writeback still outstanding; flags
// RAW hazards on either source and WAW hazards on the destination.
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int NREGS_P = NREGS,
  parameter int AW_P    = AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW_P-1:0] set_addr,
  input  logic            clr_en,
  input  logic [AW_P-1:0] clr_addr,
  input  logic [AW_P-1:0] rs1,
  input  logic [AW_P-1:0] rs2,
  input  logic [AW_P-1:0] rd,
  input  logic            rd_we,
  output logic            hazard
);
  localparam logic [AW_P-1:0] R0 = AW_P'(REG_ZERO);

  logic [NREGS_P-1:0] busy;
  logic               rs1_pending;
  logic               rs2_pending;
  logic               rd_pending;

  // A writeback landing this cycle releases the register immediately.
  assign rs1_pending = busy[rs1] && (rs1 != R0) && !(clr_en && (clr_addr == rs1));
  assign rs2_pending = busy[rs2] && (rs2 != R0) && !(clr_en && (clr_addr == rs2));
  assign rd_pending  = rd_we && busy[rd] && (rd != R0) && !(clr_en && (clr_addr == rd));
  assign hazard      = rs1_pending || rs2_pending || rd_pending;

  // The set is written after the clear so a same-cycle set of one register wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (clr_en && (clr_addr != R0)) busy[clr_addr] <= 1'b0;
      if (set_en && (set_addr != R0)) busy[set_addr] <= 1'b1;
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: accepts decoded instructions, reads the register file, forwards
// same-cycle writebacks and presents registered operands to execute.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int NREGS_P = NREGS,
  parameter int AW_P    = AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW_P-1:0]    req_rs1,
  input  logic [AW_P-1:0]    req_rs2,
  input  logic [AW_P-1:0]    req_rd,
  input  logic               req_rd_we,
  output logic [AW_P-1:0]    rf_raddr1,
  output logic [AW_P-1:0]    rf_raddr2,
  input  logic [WIDTH_P-1:0] rf_rdata1,
  input  logic [WIDTH_P-1:0] rf_rdata2,
  input  logic               wb_valid,
  input  logic [AW_P-1:0]    wb_addr,
  input  logic [WIDTH_P-1:0] wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_P-1:0] op_a,
  output logic [WIDTH_P-1:0] op_b,
  output logic [AW_P-1:0]    out_rd,
  output logic               out_rd_we
);
  localparam logic [AW_P-1:0] R0 = AW_P'(REG_ZERO);

  logic               hazard;
  logic               slot_free;
  logic               accept;
  logic [AW_P-1:0]    held_rs1;
  logic [AW_P-1:0]    held_rs2;
  logic               fwd1;
  logic               fwd2;
  logic [WIDTH_P-1:0] fwd_data1;
  logic [WIDTH_P-1:0] fwd_data2;

  // Handshake: a transfer happens on any rising edge where valid and ready are
  // both high; ready never depends on valid on the same side.
  assign slot_free = !out_valid || out_ready;
  assign req_ready = slot_free && !hazard;
  assign accept    = req_valid && req_ready;

  // Keep presenting the held addresses so rf_rdata stays valid while stalled.
  assign rf_raddr1 = accept ? req_rs1 : held_rs1;
  assign rf_raddr2 = accept ? req_rs2 : held_rs2;

  operand_fetch_scoreboard #(
    .NREGS_P(NREGS_P),
    .AW_P   (AW_P)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && req_rd_we),
    .set_addr(req_rd),
    .clr_en  (wb_valid),
    .clr_addr(wb_addr),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .rd      (req_rd),
    .rd_we   (req_rd_we),
    .hazard  (hazard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
      held_rs1  <= '0;
      held_rs2  <= '0;
      fwd1      <= 1'b0;
      fwd2      <= 1'b0;
      fwd_data1 <= '0;
      fwd_data2 <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_rd    <= req_rd;
      out_rd_we <= req_rd_we;
      held_rs1  <= req_rs1;
      held_rs2  <= req_rs2;
      // The rf sees this cycle's write only after the read, so capture it here.
      fwd1      <= wb_valid && (wb_addr == req_rs1) && (req_rs1 != R0);
      fwd2      <= wb_valid && (wb_addr == req_rs2) && (req_rs2 != R0);
      fwd_data1 <= wb_data;
      fwd_data2 <= wb_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (out_valid) begin
      if (fwd1)                op_a = fwd_data1;
      else if (held_rs1 != R0) op_a = rf_rdata1;
      if (fwd2)                op_b = fwd_data2;
      else if (held_rs2 != R0) op_b = rf_rdata2;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model, random plus directed stimulus,
// expected-operand queue checked by an independent output monitor.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int W  = WIDTH;
  localparam int A  = AW;
  localparam int N  = NREGS;
  localparam int EW = 1 + A + 2 * W;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [A-1:0] req_rs1, req_rs2, req_rd;
  logic         req_rd_we;
  logic [A-1:0] rf_raddr1, rf_raddr2;
  logic [W-1:0] rf_rdata1, rf_rdata2;
  logic         wb_valid;
  logic [A-1:0] wb_addr;
  logic [W-1:0] wb_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] op_a, op_b;
  logic [A-1:0] out_rd;
  logic         out_rd_we;

  // clock / reset
  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_rd_we(req_rd_we),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  // register file model: synchronous read of the pre-write contents
  logic [W-1:0] rf_mem [N];
  logic         rf_load;

  function automatic logic [W-1:0] init_val(input int i);
    if (i == 0) return 32'hDEAD_BEEF;
    if (i == 3) return 32'h11;
    if (i == 4) return 32'h22;
    return 32'hA000_0000 | (i * 32'h0101);
  endfunction

  always @(posedge clk) begin
    rf_rdata1 <= rf_mem[rf_raddr1];
    rf_rdata2 <= rf_mem[rf_raddr2];
    if (rf_load) begin
      for (int i = 0; i < N; i++) rf_mem[i] <= init_val(i);
    end else if (wb_valid) begin
      rf_mem[wb_addr] <= wb_data;
    end
  end

  // reference model state
  logic [N-1:0] busy_m;
  logic         ov_m;
  logic [A-1:0] slot_rd_m;
  logic         slot_we_m;
  logic [A-1:0] wb_pend[$];
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // An instruction must wait while any register it reads, or writes, still has
  // an outstanding write that is not landing in this very cycle.
  function automatic logic model_hazard(input logic [A-1:0] rs1, rs2, rd, input logic we,
                                        input logic wv, input logic [A-1:0] wa);
    logic [A-1:0] regs [3];
    logic h;
    regs = '{rs1, rs2, rd};
    h = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2 && !we) continue;
      if (regs[i] != 0 && busy_m[regs[i]] && !(wv && wa == regs[i])) h = 1'b1;
    end
    return h;
  endfunction

  // Architectural value of a register as seen by an instruction issued now.
  function automatic logic [W-1:0] reg_value(input logic [A-1:0] rs, input logic wv,
                                             input logic [A-1:0] wa, input logic [W-1:0] wd);
    if (rs == 0) return '0;
    if (wv && wa == rs) return wd;
    return rf_mem[rs];
  endfunction

  // driver: one cycle of stimulus, starting just after a rising edge
  task automatic step(input logic v, input logic [A-1:0] rs1, rs2, rd, input logic we,
                      input logic wv, input logic [A-1:0] wa, input logic [W-1:0] wd,
                      input logic ordy, output logic acc);
    logic exp_ready;
    req_valid = v;  req_rs1 = rs1;  req_rs2 = rs2;  req_rd = rd;  req_rd_we = we;
    wb_valid  = wv; wb_addr = wa;   wb_data = wd;   out_ready = ordy;
    @(negedge clk);
    exp_ready = (!ov_m || ordy) && !model_hazard(rs1, rs2, rd, we, wv, wa);
    check("req_ready", req_ready, exp_ready);
    check("out_valid", out_valid, ov_m);
    check("busy", dut.u_sb.busy, busy_m);
    acc = v && exp_ready;
    if (acc) exp_q.push_back({we, rd, reg_value(rs2, wv, wa, wd), reg_value(rs1, wv, wa, wd)});
    if (ov_m && ordy && slot_we_m && slot_rd_m != 0) wb_pend.push_back(slot_rd_m);
    @(posedge clk);
    if (wv && wa != 0) busy_m[wa] = 1'b0;
    if (acc && we && rd != 0) busy_m[rd] = 1'b1;
    if (acc) begin
      ov_m = 1'b1; slot_rd_m = rd; slot_we_m = we;
    end else if (ordy) begin
      ov_m = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    wb_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    busy_m = '0; ov_m = 1'b0; slot_rd_m = '0; slot_we_m = 1'b0;
    exp_q.delete();
    wb_pend.delete();
  endtask

  // monitor: compares the presented slot against the head of the expected queue
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = exp_q[0];
            check("op_a", op_a, e[W-1:0]);
            check("op_b", op_b, e[2*W-1:W]);
            check("out_rd", out_rd, e[2*W+A-1:2*W]);
            check("out_rd_we", out_rd_we, e[2*W+A]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end else begin
          check("idle_op_a", op_a, 0);
          check("idle_op_b", op_b, 0);
        end
      end
    end
  end

  initial begin
    logic a;
    logic hv, hwe, last_acc, wv, ordy;
    logic [A-1:0] h1, h2, hd, wa;
    logic [W-1:0] wd;
    int idx;

    req_valid = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0; req_rd_we = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
    reset = 1'b1; rf_load = 1'b1;
    @(posedge clk); #1;
    rf_load = 1'b0;
    do_reset(2);

    // idle after reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, a);
    check("reset_out_rd", out_rd, 0);
    check("reset_out_rd_we", out_rd_we, 0);

    // r3 + r4 -> r5, then RAW on r5 held with out_ready low for 3 cycles
    step(1, 3, 4, 5, 1, 0, 0, 0, 0, a);
    check("first_accept", a, 1);
    repeat (3) step(1, 5, 4, 6, 1, 0, 0, 0, 0, a);
    step(1, 5, 4, 6, 1, 0, 0, 0, 1, a);
    step(1, 5, 4, 6, 1, 1, 5, 32'hAB, 0, a);
    check("raw_accept_on_wb", a, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, a);

    // back-to-back with out_ready high
    step(1, 2, 3, 0, 0, 0, 0, 0, 1, a);
    step(1, 4, 1, 0, 0, 0, 0, 0, 1, a);
    step(1, 3, 3, 8, 0, 0, 0, 0, 1, a);
    check("b2b_accept", a, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, a);

    // r0: never busy, never forwarded
    step(1, 0, 3, 0, 1, 1, 0, 32'h55, 1, a);
    step(1, 0, 0, 0, 1, 1, 0, 32'h66, 1, a);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, a);

    // WAW stall on r7, then reset releases it
    step(1, 1, 2, 7, 1, 0, 0, 0, 1, a);
    repeat (3) step(1, 2, 1, 7, 1, 0, 0, 0, 1, a);
    check("waw_stalled", a, 0);
    do_reset(2);
    step(1, 2, 1, 7, 1, 0, 0, 0, 1, a);
    check("accept_after_reset", a, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, a);
    do_reset(1);

    // randomized traffic; a stalled request is held until accepted
    hv = 0; hwe = 0; h1 = 0; h2 = 0; hd = 0; last_acc = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!hv || last_acc) begin
        hv  = ($urandom_range(0, 3) != 0);
        h1  = A'($urandom_range(0, 7));
        h2  = A'($urandom_range(0, 7));
        hd  = A'($urandom_range(0, 7));
        hwe = ($urandom_range(0, 3) != 0);
      end
      wv = 0; wa = 0; wd = $urandom;
      if (wb_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, wb_pend.size() - 1);
        wa = wb_pend[idx];
        wb_pend.delete(idx);
        wv = 1;
      end else if ($urandom_range(0, 19) == 0) begin
        wv = 1;
      end
      ordy = ($urandom_range(0, 9) < 7);
      step(hv, h1, h2, hd, hwe, wv, wa, wd, ordy, last_acc);
    end

    // drain the slot and any outstanding writebacks
    repeat (40) begin
      wv = 0; wa = 0; wd = $urandom;
      if (wb_pend.size() > 0) begin
        wa = wb_pend.pop_front();
        wv = 1;
      end
      step(0, 0, 0, 0, 0, wv, wa, wd, 1, a);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
